// File: rtl/femto_mem_arbiter.sv
// femto_mem_arbiter
//   Two-master arbiter sharing one FemtoRV32-style memory port between the
//   core (port 0) and a secondary requester such as DMA or debug (port 1).
//   Each one-cycle request strobe is captured, then placed on the shared
//   port one access at a time. Each port gets its own busy flags and read data.
//
// Ports
//   clk, reset        : system clock, asynchronous active-low reset
//   pN_addr/wdata     : request address / write data, sampled on strobe
//   pN_wmask          : byte write mask, nonzero = write strobe
//   pN_rstrb          : read strobe
//   pN_rdata          : read data, holds until the next read on the port ends
//   pN_rbusy/wbusy    : read / write outstanding on that port
//   m_addr/wdata      : shared address / write data (held from issue to done)
//   m_wmask/m_rstrb   : one-cycle shared write / read strobes
//   m_rdata           : shared read data
//   m_rbusy/m_wbusy   : memory busy
//   m_owner           : currently granted port, holds last grant when idle
//
// Configuration
//   ARB_ROUND_ROBIN_EN : when defined, a tie is granted to the port opposite
//                        the last grant. When undefined, port 0 always wins.

module femto_mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    input  logic [3:0]            p0_wmask,
    input  logic                  p0_rstrb,
    output logic [31:0]           p0_rdata,
    output logic                  p0_rbusy,
    output logic                  p0_wbusy,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    input  logic [3:0]            p1_wmask,
    input  logic                  p1_rstrb,
    output logic [31:0]           p1_rdata,
    output logic                  p1_rbusy,
    output logic                  p1_wbusy,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wmask,
    output logic                  m_rstrb,
    input  logic [31:0]           m_rdata,
    input  logic                  m_rbusy,
    input  logic                  m_wbusy,
    output logic                  m_owner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ISSUE = 3'b010,
        S_WAIT  = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic [1:0] pend_q, pend_d;
    logic [1:0] infl_q, infl_d;
    logic [1:0] kind_wr_q, kind_wr_d;
    logic [1:0] rbusy_q, rbusy_d;
    logic [1:0] wbusy_q, wbusy_d;

    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [ADDR_WIDTH-1:0] addr_d [2];
    logic [31:0]           wdata_q [2];
    logic [31:0]           wdata_d [2];
    logic [3:0]            wmask_q [2];
    logic [3:0]            wmask_d [2];
    logic [31:0]           rdata_q [2];
    logic [31:0]           rdata_d [2];

    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [31:0]           m_wdata_q, m_wdata_d;
    logic [3:0]            m_wmask_q, m_wmask_d;
    logic                  m_rstrb_q, m_rstrb_d;
    logic                  owner_q, owner_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  lg_q, lg_d;
`endif

    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [31:0]           req_wdata [2];
    logic [3:0]            req_wmask [2];
    logic [1:0]            req_rstrb;
    logic                  win;

    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;
    assign req_wmask[0] = p0_wmask;
    assign req_wmask[1] = p1_wmask;
    assign req_rstrb    = {p1_rstrb, p0_rstrb};

    // Grant selection among pending ports
    always_comb begin
        win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (pend_q == 2'b11) begin
            win = ~lg_q;
        end else begin
            win = ~pend_q[0];
        end
`else
        win = ~pend_q[0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        infl_d    = infl_q;
        kind_wr_d = kind_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = 4'b0000;
        m_rstrb_d = 1'b0;
        owner_d   = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
        lg_d      = lg_q;
`endif

        // A strobe is accepted only when the port has nothing outstanding;
        // a nonzero mask turns a simultaneous read strobe into a write.
        for (int i = 0; i < 2; i++) begin
            if ((req_rstrb[i] || (req_wmask[i] != 4'b0000)) && !pend_q[i] && !infl_q[i]) begin
                pend_d[i]    = 1'b1;
                addr_d[i]    = req_addr[i];
                wdata_d[i]   = req_wdata[i];
                wmask_d[i]   = req_wmask[i];
                kind_wr_d[i] = (req_wmask[i] != 4'b0000);
            end
        end

        // Shared-port outputs are registered, so the strobe is loaded on the
        // IDLE->ISSUE edge and is visible for exactly the ISSUE cycle.
        unique case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    owner_d   = win;
                    m_addr_d  = addr_q[win];
                    m_wdata_d = wdata_q[win];
                    if (kind_wr_q[win]) begin
                        m_wmask_d = wmask_q[win];
                    end else begin
                        m_rstrb_d = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pend_d[owner_q] = 1'b0;
                infl_d[owner_q] = 1'b1;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                if (!m_rbusy && !m_wbusy) begin
                    if (!kind_wr_q[owner_q]) begin
                        rdata_d[owner_q] = m_rdata;
                    end
                    infl_d[owner_q] = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    lg_d = owner_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < 2; i++) begin
            rbusy_d[i] = (pend_d[i] | infl_d[i]) & ~kind_wr_d[i];
            wbusy_d[i] = (pend_d[i] | infl_d[i]) &  kind_wr_d[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pend_q    <= 2'b00;
            infl_q    <= 2'b00;
            kind_wr_q <= 2'b00;
            rbusy_q   <= 2'b00;
            wbusy_q   <= 2'b00;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= 4'b0000;
            m_rstrb_q <= 1'b0;
            owner_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lg_q      <= 1'b1;
`endif
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            infl_q    <= infl_d;
            kind_wr_q <= kind_wr_d;
            rbusy_q   <= rbusy_d;
            wbusy_q   <= wbusy_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wmask_q <= m_wmask_d;
            m_rstrb_q <= m_rstrb_d;
            owner_q   <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            lg_q      <= lg_d;
`endif
            rdata_q   <= rdata_d;
        end
    end

    // Request latches are only meaningful while pendN/inflightN is set,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign p0_rbusy = rbusy_q[0];
    assign p1_rbusy = rbusy_q[1];
    assign p0_wbusy = wbusy_q[0];
    assign p1_wbusy = wbusy_q[1];
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wmask  = m_wmask_q;
    assign m_rstrb  = m_rstrb_q;
    assign m_owner  = owner_q;

endmodule
